// File: rtl/lorenz_uart_pkg.sv
// Shared constants for the Lorenz UART packetizer: sync byte, FSM encoding, frame length.
package lorenz_uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [2:0] ST_SYNC_WAIT = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACT  = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;
  localparam logic [2:0] ST_WAIT_REL  = 3'd6;

  // Bytes per frame: sync + three coordinates + checksum.
  function automatic int unsigned frame_len(input int unsigned sample_w);
    return 2 + 3 * (sample_w / 8);
  endfunction

endpackage

// File: rtl/lorenz_uart_packetizer_if.sv
// Sample handshake plus transmitter start/data/active/done bundle.
interface lorenz_uart_packetizer_if #(
  parameter int unsigned SAMPLE_W = 32
);
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_x;
  logic [SAMPLE_W-1:0] sample_y;
  logic [SAMPLE_W-1:0] sample_z;
  logic                sample_ready;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                tx_active;
  logic                tx_done;

  // Environment side: sample source and byte transmitter.
  modport master (
    output sample_valid, sample_x, sample_y, sample_z, tx_active, tx_done,
    input  sample_ready, tx_start, tx_data
  );

  // Packetizer side.
  modport slave (
    input  sample_valid, sample_x, sample_y, sample_z, tx_active, tx_done,
    output sample_ready, tx_start, tx_data
  );
endinterface

// File: rtl/lorenz_uart_packetizer_frame_byte_mux.sv
// Combinational selection of frame byte N: sync, payload MSB-first, or checksum.
module frame_byte_mux #(
  parameter int unsigned SAMPLE_W = 32,
  parameter int unsigned IDX_W    = 4
) (
  input  logic [3*SAMPLE_W-1:0] shadow,
  input  logic [IDX_W-1:0]      byte_idx,
  input  logic [7:0]            sync_byte,
  input  logic [7:0]            checksum,
  output logic [7:0]            byte_c,
  output logic                  last_c
);
  localparam int unsigned SH_W      = 3 * SAMPLE_W;
  localparam int unsigned PAY_BYTES = SH_W / 8;
  localparam int unsigned N_BYTES   = PAY_BYTES + 2;

  assign last_c = (byte_idx == IDX_W'(N_BYTES - 1));

  // Index 0 is sync, 1..PAY_BYTES walk the shadow from its MSB, last is checksum.
  always_comb begin
    byte_c = sync_byte;
    for (int unsigned i = 0; i < PAY_BYTES; i++) begin
      if (byte_idx == IDX_W'(i + 1)) byte_c = shadow[SH_W - 1 - 8*i -: 8];
    end
    if (last_c) byte_c = checksum;
  end
endmodule

// File: rtl/lorenz_uart_packetizer.sv
// Frames one (x,y,z) sample into sync/payload/checksum bytes for the UART transmitter.
module lorenz_uart_packetizer
  import lorenz_uart_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 32,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  lorenz_uart_packetizer_if.slave bus,
  output logic                   frame_busy,
  output logic [DROP_CNT_W-1:0]  drop_count
);
  localparam int unsigned N_BYTES = frame_len(SAMPLE_W);
  localparam int unsigned IDX_W   = $clog2(N_BYTES);
  localparam int unsigned SH_W    = 3 * SAMPLE_W;

  logic [2:0]            state, state_nxt;
  logic [SH_W-1:0]       shadow, shadow_nxt;
  logic [7:0]            sum, sum_nxt;
  logic [IDX_W-1:0]      byte_idx, byte_idx_nxt;
  logic                  frame_busy_nxt;
  logic [DROP_CNT_W-1:0] drop_nxt;
  logic [7:0]            tx_data_nxt;
  logic [7:0]            byte_c;
  logic                  last_c;

  frame_byte_mux #(
    .SAMPLE_W (SAMPLE_W),
    .IDX_W    (IDX_W)
  ) u_byte_mux (
    .shadow    (shadow),
    .byte_idx  (byte_idx),
    .sync_byte (SYNC_BYTE),
    .checksum  (8'(8'd0 - sum)),
    .byte_c    (byte_c),
    .last_c    (last_c)
  );

  // Next-state, datapath and drop-counter decisions.
  always_comb begin
    state_nxt      = state;
    shadow_nxt     = shadow;
    sum_nxt        = sum;
    byte_idx_nxt   = byte_idx;
    frame_busy_nxt = frame_busy;
    tx_data_nxt    = bus.tx_data;
    drop_nxt       = drop_count;

    if (bus.sample_valid && (state != ST_IDLE) && (drop_count != '1))
      drop_nxt = drop_count + DROP_CNT_W'(1);

    case (state)
      ST_SYNC_WAIT: if (!bus.tx_active && !bus.tx_done) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (bus.sample_valid) begin
          shadow_nxt     = {bus.sample_x, bus.sample_y, bus.sample_z};
          sum_nxt        = '0;
          byte_idx_nxt   = '0;
          frame_busy_nxt = 1'b1;
          state_nxt      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_data_nxt = byte_c;
        sum_nxt     = sum + byte_c;
        state_nxt   = ST_START;
      end
      ST_START:     state_nxt = ST_WAIT_ACT;
      ST_WAIT_ACT:  if (bus.tx_active) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.tx_done) state_nxt = ST_WAIT_REL;
      ST_WAIT_REL: begin
        if (!bus.tx_done) begin
          if (last_c) begin
            frame_busy_nxt = 1'b0;
            state_nxt      = ST_IDLE;
          end else begin
            byte_idx_nxt = byte_idx + IDX_W'(1);
            state_nxt    = ST_LOAD;
          end
        end
      end
      default: state_nxt = ST_SYNC_WAIT;
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_SYNC_WAIT;
      shadow           <= '0;
      sum              <= '0;
      byte_idx         <= '0;
      frame_busy       <= 1'b0;
      drop_count       <= '0;
      bus.tx_data      <= 8'h00;
      bus.tx_start     <= 1'b0;
      bus.sample_ready <= 1'b0;
    end else begin
      state            <= state_nxt;
      shadow           <= shadow_nxt;
      sum              <= sum_nxt;
      byte_idx         <= byte_idx_nxt;
      frame_busy       <= frame_busy_nxt;
      drop_count       <= drop_nxt;
      bus.tx_data      <= tx_data_nxt;
      bus.tx_start     <= (state_nxt == ST_START);
      bus.sample_ready <= (state_nxt == ST_IDLE);
    end
  end
endmodule

// File: doc/lorenz_uart_packetizer.md
Name: lorenz_uart_packetizer

Overview:
- Upstream feeder for the UART byte transmitter in the Lorenz attractor datapath.
- Accepts one (x, y, z) fixed-point sample per handshake and serialises it into a framed byte stream: sync byte, payload bytes MSB-first, checksum byte.
- Drives the transmitter's start/data inputs and paces each byte off its active/done outputs.
- Counts samples dropped while a frame is in flight.

Parameters:
- SAMPLE_W, 32, bits per coordinate; must be a multiple of 8, range 8..32.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  x/y/z valid this cycle
- sample_x  in  SAMPLE_W  x coordinate, two's complement
- sample_y  in  SAMPLE_W  y coordinate
- sample_z  in  SAMPLE_W  z coordinate
- sample_ready  out  1  high when a sample will be accepted this cycle
- tx_start  out  1  one-cycle start strobe to the transmitter
- tx_data  out  8  byte to transmit
- tx_active  in  1  transmitter busy
- tx_done  in  1  transmitter byte complete; may stay high for several cycles
- frame_busy  out  1  frame in progress
- drop_count  out  DROP_CNT_W  samples dropped since reset, saturating

Behaviour:
- Reset (synchronous, active-high) values: sample_ready=0, tx_start=0, tx_data=8'h00, frame_busy=0, drop_count=0, state=SYNC_WAIT.
- Frame layout: N = 2 + 3*SAMPLE_W/8 bytes (14 at default).
  - Byte 0: SYNC_BYTE.
  - Next: x bytes MSB-first, then y, then z.
  - Last: checksum = (256 - (sum of all preceding bytes mod 256)) mod 256, so the 8-bit sum of the whole frame is 0.
- States:
  - SYNC_WAIT: wait until tx_active=0 and tx_done=0, covering reset mid-byte because the transmitter is not reset with this block. Then go to IDLE.
  - IDLE: sample_ready=1. If sample_valid=1, latch x/y/z into a shadow register, clear the running checksum, set byte index to 0, set frame_busy=1, and go to LOAD.
  - LOAD: select the current byte into tx_data. If it is the last byte, drive the checksum instead. Add the byte to the running sum. Go to START.
  - START: tx_start=1 for exactly this cycle; tx_data stays stable. Go to WAIT_ACT.
  - WAIT_ACT: hold until tx_active=1, then go to WAIT_DONE.
  - WAIT_DONE: hold until tx_done=1, then go to WAIT_REL.
  - WAIT_REL: hold until tx_done=0. If the last byte was just sent, clear frame_busy and go to IDLE; otherwise increment the byte index and go to LOAD.
- tx_data holds its value from LOAD until the next LOAD; it never changes while tx_active=1.
- Drops: sample_valid=1 in any state other than IDLE increments drop_count (saturating at all-ones). The sample is discarded; the frame in flight is unaffected.
- sample_ready=1 only in IDLE, so the accept cycle never counts as a drop.
- Latency: tx_start asserts 2 cycles after the accepting edge (IDLE→LOAD→START). Between byte k done-release and byte k+1 tx_start there are 2 cycles.
- Reset asserted mid-frame: the frame is abandoned, outputs go to reset values, and the block resynchronises via SYNC_WAIT. No partial frame resumes.
- tx_active stuck at 0 after tx_start: the block hangs in WAIT_ACT. No timeout; this is a transmitter fault.

Decomposition:
- Shared package lorenz_uart_pkg: SYNC_BYTE default, state encoding localparams (3 bits), frame-length function.
- One natural sub-module: frame_byte_mux, a combinational byte select over the shadow register indexed by byte number. The rest stays flat.

Test Plan (bench uses the real transmitter with CLKS_PER_BIT=4):
- Single sample x=32'h00000001, y=0, z=0 → 14 bytes decoded on the serial line: A5 00 00 00 01 00×8 5A; frame_busy falls after the last byte.
- x=32'h12345678, y=32'h9ABCDEF0, z=32'h0F0F0F0F → payload bytes in MSB-first order; checksum makes the 8-bit sum of all 14 bytes equal 00.
- Three sample_valid pulses during a frame → drop_count=3; next sample accepted only after frame_busy=0; sample_ready=0 throughout the frame.
- Force drop_count near saturation (DROP_CNT_W=2), then 5 drops → drop_count=3, no wrap.
- Assert rst while the transmitter is mid-byte 5 → tx_start stays 0 until the transmitter returns idle. A new sample then produces a complete, correct frame starting with A5.
- Hold tx_done high 3 cycles per byte (override model) → exactly one tx_start per byte; no duplicated or skipped bytes.
